// File: rtl/vx_tcu_drl_kstep_seq_pkg.sv
// Shared TCU DRL sequencer types: format IDs, exception word, FSM states.
// Also holds the tile exception merge rule used by the sequencer.
package vx_tcu_drl_kstep_seq_pkg;

    localparam int TCU_MAX_INPUTS = 8;

    localparam logic [2:0] TCU_FP32_ID = 3'd0;
    localparam logic [2:0] TCU_FP16_ID = 3'd1;
    localparam logic [2:0] TCU_BF16_ID = 3'd2;
    localparam logic [2:0] TCU_TF32_ID = 3'd3;
    localparam logic [2:0] TCU_FP8_ID  = 3'd4;
    localparam logic [2:0] TCU_BF8_ID  = 3'd5;

    typedef struct packed {
        logic sign;
        logic is_nan;
        logic is_inf;
    } fedp_excep_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_RESP
    } kstep_state_e;

    // FP16 is always present; other formats follow build-time enables.
    function automatic logic tcu_fmt_supported(input logic [2:0] fmtf);
        logic ok;
        ok = (fmtf == TCU_FP16_ID);
`ifdef TCU_BF16_ENABLE
        ok = ok | (fmtf == TCU_BF16_ID);
`endif
`ifdef TCU_TF32_ENABLE
        ok = ok | (fmtf == TCU_TF32_ID);
`endif
`ifdef TCU_FP8_ENABLE
        ok = ok | (fmtf == TCU_FP8_ID);
`endif
`ifdef TCU_BF8_ENABLE
        ok = ok | (fmtf == TCU_BF8_ID);
`endif
        return ok;
    endfunction

    // Accumulate one step's flags into the tile word. Opposite-signed
    // infinities produce NaN; NaN never clears; sign only means
    // something while the result is infinite.
    function automatic fedp_excep_t tcu_excep_merge(
        input fedp_excep_t acc,
        input fedp_excep_t n
    );
        fedp_excep_t r;
        r.is_nan = acc.is_nan | n.is_nan
                 | (acc.is_inf & n.is_inf & (acc.sign ^ n.sign));
        r.is_inf = (acc.is_inf | n.is_inf) & ~r.is_nan;
        r.sign   = r.is_inf & (acc.is_inf ? acc.sign : n.sign);
        return r;
    endfunction

endpackage

// File: rtl/vx_tcu_drl_credit_cnt.sv
// Outstanding-step credit counter for the DRL k-step sequencer.
// Ports: clk, reset (async high), clr, inc, dec -> count, full, empty.
// inc is dropped when full, dec is dropped when empty (no wrap).
module vx_tcu_drl_credit_cnt #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          inc_ok;
    logic          dec_ok;

    assign full   = (count_q == CW'(MAX));
    assign empty  = (count_q == '0);
    assign inc_ok = inc & ~full;
    assign dec_ok = dec & ~empty;
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc_ok & ~dec_ok) begin
            count_d = count_q + CW'(1);
        end else if (~inc_ok & dec_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vx_tcu_drl_kstep_seq.sv
// TCU DRL k-step sequencer: takes one MMA tile request, issues ksteps+1
// FEDP steps under a credit limit, merges returned exception flags into
// a sticky tile word and returns it with the request tag.
// Ports:
//   req_*  : tile request (valid/ready), format, ksteps-1, lane mask, tag
//   dp_*   : per-step issue to datapath (valid/ready), step index, first/last
//   ex_*   : per-step exception return, in issue order
//   rsp_*  : tile response (valid/ready), tag, merged exceptions, format error
//   busy   : sequencer not idle
module vx_tcu_drl_kstep_seq
    import vx_tcu_drl_kstep_seq_pkg::*;
#(
    parameter int KW      = 4,
    parameter int TAG_W   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_fmtf,
    input  logic [KW-1:0]             req_ksteps,
    input  logic [TCU_MAX_INPUTS-1:0] req_vld_mask,
    input  logic [TAG_W-1:0]          req_tag,

    output logic                      dp_valid,
    input  logic                      dp_ready,
    output logic [KW-1:0]             dp_step,
    output logic [2:0]                dp_fmtf,
    output logic [TCU_MAX_INPUTS-1:0] dp_vld_mask,
    output logic                      dp_first,
    output logic                      dp_last,

    input  logic                      ex_valid,
    input  fedp_excep_t               ex_data,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [TAG_W-1:0]          rsp_tag,
    output fedp_excep_t               rsp_excep,
    output logic                      rsp_err,

    output logic                      busy
);

    localparam int CW = $clog2(MAX_OUT + 1);

    kstep_state_e              state_q;
    // One extra bit so the count can step past ksteps=2^KW-1 on the
    // final handshake without wrapping back to 0.
    logic [KW:0]               issue_cnt_q;
    logic [KW-1:0]             ksteps_q;
    logic [2:0]                fmtf_q;
    logic [TCU_MAX_INPUTS-1:0] mask_q;
    logic [TAG_W-1:0]          tag_q;
    fedp_excep_t               acc_q;
    logic                      err_q;

    logic [CW-1:0]             out_cnt;
    logic                      out_full;
    logic                      out_empty;

    logic                      req_fire;
    logic                      dp_fire;
    logic                      ex_take;
    logic                      drain_done;
    logic                      fmt_ok;

    assign req_ready = (state_q == ST_IDLE);
    assign req_fire  = req_valid & req_ready;
    assign fmt_ok    = tcu_fmt_supported(req_fmtf);

    assign dp_valid  = (state_q == ST_ISSUE) & ~out_full;
    assign dp_fire   = dp_valid & dp_ready;

    // Returns only count while a tile is active and something is owed.
    assign ex_take   = ex_valid & ~out_empty
                     & ((state_q == ST_ISSUE) | (state_q == ST_DRAIN));

    // The last return may land in the cycle we would otherwise wait on.
    assign drain_done = out_empty | ((out_cnt == CW'(1)) & ex_take);

    assign dp_step     = issue_cnt_q[KW-1:0];
    assign dp_first    = (issue_cnt_q == '0);
    assign dp_last     = (issue_cnt_q == {1'b0, ksteps_q});
    assign dp_fmtf     = fmtf_q;
    assign dp_vld_mask = mask_q;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_tag   = tag_q;
    assign rsp_excep = acc_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != ST_IDLE);

    vx_tcu_drl_credit_cnt #(
        .MAX (MAX_OUT),
        .CW  (CW)
    ) u_credit (
        .clk   (clk),
        .reset (reset),
        .clr   (req_fire),
        .inc   (dp_fire),
        .dec   (ex_take),
        .count (out_cnt),
        .full  (out_full),
        .empty (out_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            ksteps_q    <= '0;
            fmtf_q      <= '0;
            mask_q      <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            if (ex_take) begin
                acc_q <= tcu_excep_merge(acc_q, ex_data);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        fmtf_q      <= req_fmtf;
                        ksteps_q    <= req_ksteps;
                        mask_q      <= req_vld_mask;
                        tag_q       <= req_tag;
                        acc_q       <= '0;
                        issue_cnt_q <= '0;
                        err_q       <= ~fmt_ok;
                        state_q     <= fmt_ok ? ST_ISSUE : ST_RESP;
                    end
                end
                ST_ISSUE: begin
                    if (dp_fire) begin
                        issue_cnt_q <= issue_cnt_q + (KW+1)'(1);
                        if (dp_last) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_tcu_drl_kstep_seq.sv
// Testbench for vx_tcu_drl_kstep_seq: directed and randomized tiles
// checked against an infinity-class model of the exception merge.
module tb_vx_tcu_drl_kstep_seq;
    import vx_tcu_drl_kstep_seq_pkg::*;

    localparam int KW      = 4;
    localparam int TAG_W   = 8;
    localparam int MAX_OUT = 4;
    localparam int MI      = TCU_MAX_INPUTS;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_fmtf;
    logic [KW-1:0]     req_ksteps;
    logic [MI-1:0]     req_vld_mask;
    logic [TAG_W-1:0]  req_tag;
    logic              dp_valid;
    logic              dp_ready;
    logic [KW-1:0]     dp_step;
    logic [2:0]        dp_fmtf;
    logic [MI-1:0]     dp_vld_mask;
    logic              dp_first;
    logic              dp_last;
    logic              ex_valid;
    fedp_excep_t       ex_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [TAG_W-1:0]  rsp_tag;
    fedp_excep_t       rsp_excep;
    logic              rsp_err;
    logic              busy;

    always #5 clk = ~clk;

    vx_tcu_drl_kstep_seq #(
        .KW(KW), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmtf(req_fmtf), .req_ksteps(req_ksteps),
        .req_vld_mask(req_vld_mask), .req_tag(req_tag),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_step(dp_step),
        .dp_fmtf(dp_fmtf), .dp_vld_mask(dp_vld_mask),
        .dp_first(dp_first), .dp_last(dp_last),
        .ex_valid(ex_valid), .ex_data(ex_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_tag(rsp_tag), .rsp_excep(rsp_excep), .rsp_err(rsp_err),
        .busy(busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations of the last tile run by run_tile.
    int            iss_step[$];
    bit            iss_first[$];
    bit            iss_last[$];
    logic [2:0]    iss_fmt[$];
    logic [MI-1:0] iss_mask[$];
    fedp_excep_t   ex_plan[32];
    int n_iss, dpv_bad, stall_bad, busy_bad, rsp_unstable, idle_bad;
    int max_out, rsp_cyc, last_ret_cyc, iss_at_first_ret, timeout;
    logic [TAG_W-1:0] r_tag;
    fedp_excep_t      r_ex;
    logic             r_err;

    function automatic bit fmt_ok(input logic [2:0] f);
        bit ok;
        ok = (f == TCU_FP16_ID);
`ifdef TCU_BF16_ENABLE
        ok = ok | (f == TCU_BF16_ID);
`endif
`ifdef TCU_TF32_ENABLE
        ok = ok | (f == TCU_TF32_ID);
`endif
`ifdef TCU_FP8_ENABLE
        ok = ok | (f == TCU_FP8_ID);
`endif
`ifdef TCU_BF8_ENABLE
        ok = ok | (f == TCU_BF8_ID);
`endif
        return ok;
    endfunction

    // Tile result as a running value class: finite, +inf, -inf or NaN.
    function automatic fedp_excep_t model_tile(input int n);
        int cls;
        int ni;
        fedp_excep_t r;
        cls = 0;
        for (int i = 0; i < n; i++) begin
            if (cls == 3 || ex_plan[i].is_nan) cls = 3;
            else if (ex_plan[i].is_inf) begin
                ni = ex_plan[i].sign ? 2 : 1;
                if (cls == 0) cls = ni;
                else if (cls != ni) cls = 3;
            end
        end
        case (cls)
            1:       r = 3'b001;
            2:       r = 3'b101;
            3:       r = 3'b010;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    task automatic fill_ex(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(9);
            ex_plan[i].sign   = 1'($urandom_range(1));
            ex_plan[i].is_inf = (r >= 6 && r <= 8);
            ex_plan[i].is_nan = (r == 9);
            if (r == 8) ex_plan[i].sign = 1'b1;
        end
    endtask

    task automatic run_tile(
        input logic [2:0] fmtf, input logic [KW-1:0] ks,
        input logic [TAG_W-1:0] tag, input logic [MI-1:0] mask,
        input int rdy_pct, input int lat_min, input int lat_max,
        input int hold, input int rsp_hold
    );
        int cyc, last_due, ret_idx, out_m, kn, d;
        int due_q[$];
        bit ok, done, prev_stall, exp_dpv;
        logic [KW-1:0] pstep;
        logic pfirst, plast;
        iss_step.delete(); iss_first.delete(); iss_last.delete();
        iss_fmt.delete(); iss_mask.delete();
        n_iss = 0; dpv_bad = 0; stall_bad = 0; busy_bad = 0;
        rsp_unstable = 0; idle_bad = 0; max_out = 0; rsp_cyc = -1;
        last_ret_cyc = -1; iss_at_first_ret = -1; timeout = 0;
        ok = fmt_ok(fmtf);
        kn = int'(ks) + 1;
        @(negedge clk);
        req_valid = 1'b1; req_fmtf = fmtf; req_ksteps = ks;
        req_tag = tag; req_vld_mask = mask;
        cyc = 0;
        while (!req_ready && !timeout) begin
            @(negedge clk);
            cyc++;
            if (cyc > 50) timeout = 1;
        end
        @(negedge clk);
        cyc = 1; out_m = 0; last_due = 0; ret_idx = 0;
        prev_stall = 0; done = 0; pstep = '0; pfirst = 0; plast = 0;
        while (!done && !timeout) begin
            if (cyc > 600) begin
                timeout = 1;
            end else if (rsp_valid) begin
                rsp_cyc = cyc;
                r_tag = rsp_tag; r_ex = rsp_excep; r_err = rsp_err;
                dp_ready = 1'b0;
                if (dp_valid !== 1'b0) dpv_bad++;
                for (int h = 0; h < rsp_hold; h++) begin
                    rsp_ready = 1'b0;
                    ex_valid = 1'($urandom_range(1));
                    ex_data = 3'($urandom);
                    req_valid = 1'($urandom_range(1));
                    req_tag = 8'($urandom);
                    @(negedge clk);
                    if (rsp_valid !== 1'b1 || rsp_tag !== r_tag ||
                        rsp_excep !== r_ex || rsp_err !== r_err)
                        rsp_unstable++;
                end
                rsp_ready = 1'b1; ex_valid = 1'b0; req_valid = 1'b0;
                @(negedge clk);
                rsp_ready = 1'b0;
                if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
                    idle_bad++;
                done = 1;
            end else begin
                exp_dpv = ok && (n_iss < kn) && (out_m < MAX_OUT);
                if (dp_valid !== exp_dpv) dpv_bad++;
                if (busy !== 1'b1 || req_ready !== 1'b0) busy_bad++;
                if (prev_stall && (dp_valid !== 1'b1 || dp_step !== pstep ||
                    dp_first !== pfirst || dp_last !== plast ||
                    dp_fmtf !== fmtf || dp_vld_mask !== mask))
                    stall_bad++;
                ex_valid = 1'b0;
                ex_data = 3'($urandom);
                if (due_q.size() > 0 && due_q[0] <= cyc && cyc >= hold) begin
                    if (ret_idx == 0) iss_at_first_ret = n_iss;
                    ex_valid = 1'b1;
                    ex_data = ex_plan[ret_idx];
                    ret_idx++;
                    void'(due_q.pop_front());
                    last_ret_cyc = cyc;
                    out_m--;
                end
                dp_ready = ($urandom_range(99) < rdy_pct);
                if (dp_valid && dp_ready) begin
                    iss_step.push_back(int'(dp_step));
                    iss_first.push_back(dp_first);
                    iss_last.push_back(dp_last);
                    iss_fmt.push_back(dp_fmtf);
                    iss_mask.push_back(dp_vld_mask);
                    n_iss++;
                    out_m++;
                    d = cyc + $urandom_range(lat_max, lat_min);
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    due_q.push_back(d);
                end
                if (out_m > max_out) max_out = out_m;
                prev_stall = dp_valid && !dp_ready;
                pstep = dp_step; pfirst = dp_first; plast = dp_last;
                req_valid = 1'($urandom_range(1));
                req_fmtf = 3'($urandom);
                req_ksteps = 4'($urandom);
                req_tag = 8'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        req_valid = 1'b0; dp_ready = 1'b0; ex_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({req_ready, dp_valid, rsp_valid, rsp_err, busy} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_ctl got %b want 10000",
                     {req_ready, dp_valid, rsp_valid, rsp_err, busy});
        end
        tests_run++;
        if ({rsp_tag, rsp_excep} !== 11'h0) begin
            tests_failed++;
            $display("FAIL reset_data got tag=%h ex=%b want 0/000", rsp_tag, rsp_excep);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || dp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release got rdy=%b busy=%b dpv=%b want 1/0/0",
                     req_ready, busy, dp_valid);
        end
    endtask

    task automatic test_basic();
        int bad;
        for (int i = 0; i < 4; i++) ex_plan[i] = '0;
        run_tile(TCU_FP16_ID, 4'd3, 8'hA5, 8'h3C, 100, 2, 2, 0, 1);
        bad = 0;
        for (int i = 0; i < n_iss; i++)
            if (iss_step[i] != i || iss_first[i] != (i == 0) ||
                iss_last[i] != (i == 3) || iss_fmt[i] !== TCU_FP16_ID ||
                iss_mask[i] !== 8'h3C) bad++;
        tests_run++;
        if (timeout != 0 || n_iss != 4 || bad != 0) begin
            tests_failed++;
            $display("FAIL basic_steps got to=%0d n=%0d bad=%0d want 0/4/0",
                     timeout, n_iss, bad);
        end
        tests_run++;
        if ({r_tag, r_ex, r_err} !== {8'hA5, 3'b000, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_rsp got tag=%h ex=%b err=%b want a5/000/0",
                     r_tag, r_ex, r_err);
        end
        tests_run++;
        if (rsp_cyc != last_ret_cyc + 1 ||
            dpv_bad + stall_bad + busy_bad + rsp_unstable + idle_bad != 0) begin
            tests_failed++;
            $display("FAIL basic_proto got rsp_cyc=%0d ret=%0d errs=%0d/%0d/%0d/%0d/%0d",
                     rsp_cyc, last_ret_cyc, dpv_bad, stall_bad, busy_bad,
                     rsp_unstable, idle_bad);
        end
    endtask

    task automatic test_inf_merge();
        ex_plan[0] = 3'b001;
        ex_plan[1] = 3'b101;
        run_tile(TCU_FP16_ID, 4'd1, 8'h11, 8'hFF, 100, 1, 3, 0, 0);
        tests_run++;
        if (timeout != 0 || r_ex !== 3'b010 || r_err !== 1'b0 || r_tag !== 8'h11) begin
            tests_failed++;
            $display("FAIL inf_opposite got ex=%b err=%b tag=%h want 010/0/11",
                     r_ex, r_err, r_tag);
        end
    endtask

    task automatic test_sign_nan();
        ex_plan[0] = 3'b101;
        ex_plan[1] = 3'b101;
        ex_plan[2] = 3'b100;
        run_tile(TCU_FP16_ID, 4'd2, 8'h22, 8'h0F, 80, 1, 2, 0, 0);
        tests_run++;
        if (timeout != 0 || r_ex !== 3'b101) begin
            tests_failed++;
            $display("FAIL neg_inf got ex=%b want 101", r_ex);
        end
        ex_plan[0] = 3'b010;
        run_tile(TCU_FP16_ID, 4'd0, 8'h23, 8'h0F, 100, 1, 1, 0, 0);
        tests_run++;
        if (timeout != 0 || r_ex !== 3'b010) begin
            tests_failed++;
            $display("FAIL fresh_nan got ex=%b want 010", r_ex);
        end
    endtask

    task automatic test_credit();
        fill_ex(8);
        run_tile(TCU_FP16_ID, 4'd7, 8'h33, 8'hAA, 100, 1, 1, 11, 0);
        tests_run++;
        if (timeout != 0 || iss_at_first_ret != MAX_OUT || max_out != MAX_OUT) begin
            tests_failed++;
            $display("FAIL credit_limit got to=%0d iss=%0d max=%0d want 0/4/4",
                     timeout, iss_at_first_ret, max_out);
        end
        tests_run++;
        if (n_iss != 8 || dpv_bad != 0 || rsp_cyc != last_ret_cyc + 1) begin
            tests_failed++;
            $display("FAIL credit_flow got n=%0d dpv_bad=%0d rsp=%0d ret=%0d want 8/0/ret+1",
                     n_iss, dpv_bad, rsp_cyc, last_ret_cyc);
        end
        tests_run++;
        if (r_ex !== model_tile(8)) begin
            tests_failed++;
            $display("FAIL credit_excep got %b want %b", r_ex, model_tile(8));
        end
    endtask

    task automatic test_unsupported();
        run_tile(3'b111, 4'd5, 8'h44, 8'h55, 100, 1, 1, 0, 5);
        tests_run++;
        if (timeout != 0 || n_iss != 0 || dpv_bad != 0 || rsp_cyc != 1) begin
            tests_failed++;
            $display("FAIL unsup_flow got to=%0d n=%0d dpv_bad=%0d rsp=%0d want 0/0/0/1",
                     timeout, n_iss, dpv_bad, rsp_cyc);
        end
        tests_run++;
        if ({r_tag, r_ex, r_err} !== {8'h44, 3'b000, 1'b1} || rsp_unstable != 0) begin
            tests_failed++;
            $display("FAIL unsup_rsp got tag=%h ex=%b err=%b unstable=%0d want 44/000/1/0",
                     r_tag, r_ex, r_err, rsp_unstable);
        end
    endtask

    task automatic test_latency();
        for (int l = 1; l <= 4; l++) begin
            fill_ex(1);
            run_tile(TCU_FP16_ID, 4'd0, 8'(l), 8'h01, 100, l, l, 0, 0);
            tests_run++;
            if (timeout != 0 || rsp_cyc != 2 + l || r_ex !== model_tile(1)) begin
                tests_failed++;
                $display("FAIL latency_L%0d got rsp=%0d ex=%b want %0d/%b",
                         l, rsp_cyc, r_ex, 2 + l, model_tile(1));
            end
        end
    endtask

    task automatic test_max_ksteps();
        fill_ex(16);
        run_tile(TCU_FP16_ID, 4'd15, 8'h66, 8'hC3, 70, 1, 3, 0, 0);
        tests_run++;
        if (timeout != 0 || n_iss != 16 || iss_step[n_iss-1] != 15 ||
            iss_last[n_iss-1] != 1'b1 || r_ex !== model_tile(16)) begin
            tests_failed++;
            $display("FAIL max_ksteps got to=%0d n=%0d ex=%b want 0/16/%b",
                     timeout, n_iss, r_ex, model_tile(16));
        end
    endtask

    task automatic test_random();
        logic [2:0] f;
        logic [KW-1:0] ks;
        logic [TAG_W-1:0] tg;
        logic [MI-1:0] mk;
        int kn, bad, exp_cyc;
        fedp_excep_t exp_ex;
        for (int t = 0; t < 30; t++) begin
            f  = ($urandom_range(4) == 0) ? 3'($urandom) : TCU_FP16_ID;
            ks = 4'($urandom);
            tg = 8'($urandom);
            mk = 8'($urandom);
            kn = int'(ks) + 1;
            fill_ex(kn);
            run_tile(f, ks, tg, mk, $urandom_range(100, 30), 1,
                     $urandom_range(6, 1), 0, $urandom_range(3));
            bad = 0;
            for (int i = 0; i < n_iss; i++)
                if (iss_step[i] != i || iss_first[i] != (i == 0) ||
                    iss_last[i] != (i == kn - 1) || iss_fmt[i] !== f ||
                    iss_mask[i] !== mk) bad++;
            exp_ex  = fmt_ok(f) ? model_tile(kn) : 3'b000;
            exp_cyc = fmt_ok(f) ? last_ret_cyc + 1 : 1;
            tests_run++;
            if (timeout != 0 || n_iss != (fmt_ok(f) ? kn : 0) || bad != 0 ||
                {r_tag, r_ex, r_err} !== {tg, exp_ex, ~fmt_ok(f)} ||
                rsp_cyc != exp_cyc || max_out > MAX_OUT ||
                dpv_bad + stall_bad + busy_bad + rsp_unstable + idle_bad != 0) begin
                tests_failed++;
                $display("FAIL random_%0d f=%0d ks=%0d got n=%0d bad=%0d tag=%h ex=%b err=%b cyc=%0d proto=%0d/%0d/%0d/%0d/%0d want ex=%b cyc=%0d",
                         t, f, ks, n_iss, bad, r_tag, r_ex, r_err, rsp_cyc,
                         dpv_bad, stall_bad, busy_bad, rsp_unstable, idle_bad,
                         exp_ex, exp_cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_fmtf = TCU_FP16_ID; req_ksteps = 4'd7;
        req_tag = 8'h5A; req_vld_mask = '1; dp_ready = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (dp_valid !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_issue got dpv=%b busy=%b want 1/1", dp_valid, busy);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({dp_valid, rsp_valid, busy, req_ready} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_async got %b want 0001",
                     {dp_valid, rsp_valid, busy, req_ready});
        end
        dp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            ex_valid = 1'b1;
            ex_data = 3'($urandom);
            @(negedge clk);
        end
        ex_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stale_ex got busy=%b rdy=%b want 0/1", busy, req_ready);
        end
        fill_ex(1);
        run_tile(TCU_FP16_ID, 4'd0, 8'h77, 8'h81, 100, 3, 3, 0, 0);
        tests_run++;
        if (timeout != 0 || n_iss != 1 || rsp_cyc != 5 ||
            {r_tag, r_ex, r_err} !== {8'h77, model_tile(1), 1'b0}) begin
            tests_failed++;
            $display("FAIL post_reset got to=%0d n=%0d cyc=%0d tag=%h ex=%b want 0/1/5/77/%b",
                     timeout, n_iss, rsp_cyc, r_tag, r_ex, model_tile(1));
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_fmtf = '0; req_ksteps = '0;
        req_vld_mask = '0; req_tag = '0;
        dp_ready = 1'b0; ex_valid = 1'b0; ex_data = '0; rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_inf_merge();
        test_sign_nan();
        test_credit();
        test_unsupported();
        test_latency();
        test_max_ksteps();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vx_tcu_drl_kstep_seq.md
Name: VX_tcu_drl_kstep_seq

Overview:
- Sequencer for the TCU DRL dot-product datapath. Accepts one MMA tile request, issues K per-step FEDP operations into the datapath with valid/ready, and counts outstanding steps against a credit limit.
- Merges the per-step exception flags (NaN/Inf/sign) returned by the datapath into one sticky tile-level exception word.
- Returns that word with the request tag on a response handshake.
- Sits between the TCU issue logic and the FEDP/exception datapath.

Parameters:
- KW, 4, width of step count; max steps per request = 2^KW.
- TAG_W, 8, request tag width.
- MAX_OUT, 4, maximum datapath steps in flight (credit limit); must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_fmtf  in  3  format ID (TCU_*_ID)
- req_ksteps  in  KW  step count minus one (0 → 1 step)
- req_vld_mask  in  TCU_MAX_INPUTS  lane valid mask
- req_tag  in  TAG_W  request tag
- dp_valid  out  1  step issue valid
- dp_ready  in  1  datapath accepts step
- dp_step  out  KW  step index, 0..ksteps
- dp_fmtf  out  3  latched format
- dp_vld_mask  out  TCU_MAX_INPUTS  latched mask
- dp_first  out  1  high on step 0 (datapath uses C operand)
- dp_last  out  1  high on final step
- ex_valid  in  1  per-step exception return, in issue order
- ex_data  in  fedp_excep_t  per-step exceptions {sign,is_nan,is_inf}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_tag  out  TAG_W  tag of completed request
- rsp_excep  out  fedp_excep_t  merged tile exceptions
- rsp_err  out  1  unsupported format
- busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous: state=IDLE; req_ready=1; dp_valid=0; rsp_valid=0; rsp_err=0; busy=0. All counters, the accumulator, rsp_tag and rsp_excep clear to 0.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE: req_ready=1. On req_valid, latch fmtf/ksteps/mask/tag, clear acc and counters.
  - Supported fmtf (FP16 always; BF16/TF32/FP8/BF8 per enable defines) → ISSUE.
  - Otherwise → RESP with rsp_err=1 and rsp_excep=0. No dp_valid is issued.
- ISSUE: dp_valid = (outstanding < MAX_OUT).
  - On dp_valid&dp_ready: issue_cnt++ and outstanding++.
  - On the handshake of the final step (dp_last) → DRAIN.
  - dp_step = issue_cnt; dp_first = (issue_cnt==0); dp_last = (issue_cnt==ksteps).
  - dp_* outputs are held stable while dp_valid=1 and dp_ready=0.
- Outstanding counter: +1 on issue, -1 on ex_valid. Both in the same cycle → unchanged. Never exceeds MAX_OUT.
- DRAIN: go to RESP when outstanding==0, or when outstanding==1 and ex_valid=1 in that cycle. In the second case the last merge happens in that same cycle.
- Exception merge, every ex_valid in ISSUE or DRAIN, with n=ex_data:
  - nan' = acc.nan | n.is_nan | (acc.inf & n.is_inf & (acc.sign != n.sign))
  - inf' = (acc.inf | n.is_inf) & ~nan'
  - sign' = acc.inf ? acc.sign : n.sign; sign' is forced to 0 when inf'=0.
  - NaN is sticky for the rest of the request.
- RESP: rsp_valid=1; rsp_tag/rsp_excep/rsp_err hold stable until rsp_ready. On handshake → IDLE. req_ready=1 is asserted the next cycle; there is no same-cycle response/request overlap.
- ex_valid outside ISSUE/DRAIN is ignored. An ex_valid arriving with outstanding==0 is ignored; the counter never underflows.
- Latency, 1 step, ready datapath with ex return latency L: request accepted at cycle 0; dp_valid at cycle 1; ex_valid at cycle 1+L; rsp_valid at cycle 2+L.
- With ksteps=2^KW-1, issue_cnt reaches the maximum without wrap. dp_last terminates issue before any overflow.
- req_* inputs are ignored while state != IDLE.

Decomposition:
- VX_tcu_pkg holds fedp_excep_t (already shared), the TCU_*_ID constants, and a new function tcu_excep_merge(acc, n) implementing the merge rule. The function is reused by the verification model.
- The credit/outstanding counter is a natural sub-module: VX_tcu_drl_credit_cnt (inc, dec, count, full, empty; MAX parameter).
- The FSM stays in the top module.

Test Plan:
- FP16, ksteps=3, dp_ready=1, ex_data all 0 → dp_step 0,1,2,3 with dp_first only on step 0 and dp_last only on step 3. Response: rsp_excep={sign=0,nan=0,inf=0}, rsp_tag echoed, rsp_err=0.
- ksteps=1; step0 returns +inf {0,0,1}, step1 returns -inf {1,0,1} → rsp_excep={0,1,0} (NaN from opposite-signed infs).
- ksteps=2; returns -inf, -inf, finite → rsp_excep={1,0,1}. Then a step with is_nan=1 on a fresh request → nan=1, inf=0.
- MAX_OUT=4, ksteps=7, ex held off 10 cycles → exactly 4 dp handshakes, dp_valid then 0. Each ex_valid re-enables exactly one issue. Response follows the 8th return.
- Unsupported fmtf=3'b111 → no dp_valid; rsp_valid 1 cycle after accept with rsp_err=1 and rsp_excep=0. rsp_ready held 0 for 5 cycles → outputs stable.
- Reset asserted mid-ISSUE with 2 outstanding → dp_valid/rsp_valid/busy drop immediately without waiting for clk. After release, a new FP16 ksteps=0 request completes normally; stale ex_valid pulses after reset are ignored.
